// File: rtl/keypad_entry.sv
// Keypad front end: folds decimal key presses into a 14-bit code and issues submit/change/error pulses.
// Every key takes effect at the edge that samples it; one key per cycle, no backpressure toward the scanner.
module keypad_entry #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [13:0] password_in,
  output logic        submit,
  output logic [13:0] new_password,
  output logic        change_password,
  output logic [2:0]  digit_count,
  output logic        change_mode,
  output logic        entry_error
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]    FULL = 3'(DIGITS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, NEW_ENTRY} state_e;

  state_e        state_q, state_d;
  logic [13:0]   acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [13:0]   pw_q, pw_d;
  logic [13:0]   np_q, np_d;
  logic          submit_q, submit_d;
  logic          chg_q, chg_d;
  logic          err_q, err_d;

  logic is_digit, is_clear, is_enter, is_change, full, timeout;

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_clear  = key_valid && (key_code == 4'hA);
  assign is_enter  = key_valid && (key_code == 4'hB);
  assign is_change = key_valid && (key_code == 4'hC);
  assign full      = (cnt_q == FULL);
  // A key arriving on the expiry edge wins over the timeout.
  assign timeout   = !key_valid && (state_q != IDLE) && (timer_q == TMAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      pw_q     <= '0;
      np_q     <= '0;
      submit_q <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      pw_q     <= pw_d;
      np_q     <= np_d;
      submit_q <= submit_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    np_d     = np_q;
    submit_d = 1'b0;
    chg_d    = 1'b0;
    err_d    = 1'b0;
    timer_d  = (key_valid || state_q == IDLE) ? '0 : timer_q + TW'(1);

    if (timeout) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else if (is_digit) begin
      if (!full) begin
        acc_d = acc_q * 14'd10 + {10'd0, key_code};
        cnt_d = cnt_q + 3'd1;
        if (state_q == IDLE) state_d = ENTRY;
      end
    end else if (is_enter) begin
      if (full && state_q == NEW_ENTRY) begin
        np_d  = acc_q;
        chg_d = 1'b1;
      end else if (full) begin
        pw_d     = acc_q;
        submit_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (is_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (is_change && state_q == IDLE) begin
      state_d = NEW_ENTRY;
    end
  end

  always_comb begin
    password_in     = pw_q;
    new_password    = np_q;
    submit          = submit_q;
    change_password = chg_q;
    entry_error     = err_q;
    digit_count     = cnt_q;
    change_mode     = (state_q == NEW_ENTRY);
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry; pulses are matched against a queue of expected events.
module tb_keypad_entry;

  localparam int TO = 20;
  localparam logic [2:0] K_SUB = 3'b100;
  localparam logic [2:0] K_CHG = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] password_in;
  logic        submit;
  logic [13:0] new_password;
  logic        change_password;
  logic [2:0]  digit_count;
  logic        change_mode;
  logic        entry_error;

  typedef struct {
    int          at_edge;
    logic [2:0]  kind;
    logic [13:0] pw;
    logic [13:0] np;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [2:0]  mon_k;
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          last_edge = 0;
  logic [13:0] pw_m = '0;
  logic [13:0] np_m = '0;

  keypad_entry #(.DIGITS(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .password_in     (password_in),
    .submit          (submit),
    .new_password    (new_password),
    .change_password (change_password),
    .digit_count     (digit_count),
    .change_mode     (change_mode),
    .entry_error     (entry_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    last_edge = edge_n + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [2:0] kind, input int at_edge);
    exp_q.push_back('{at_edge, kind, pw_m, np_m});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_password_in"}, password_in, 0);
    chk({tag, "_new_password"}, new_password, 0);
    chk({tag, "_submit"}, submit, 0);
    chk({tag, "_change_password"}, change_password, 0);
    chk({tag, "_entry_error"}, entry_error, 0);
    chk({tag, "_change_mode"}, change_mode, 0);
    chk({tag, "_digit_count"}, digit_count, 0);
  endtask

  // Every pulse cycle must match the next expected event exactly.
  always @(negedge clk) begin
    mon_k = {submit, change_password, entry_error};
    if (mon_k != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, mon_k}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", {29'd0, mon_k}, {29'd0, mon_e.kind});
        chk("pulse_cycle", edge_n, mon_e.at_edge);
        chk("pulse_password_in", {18'd0, password_in}, {18'd0, mon_e.pw});
        chk("pulse_new_password", {18'd0, new_password}, {18'd0, mon_e.np});
      end
    end
  end

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_all_zero("reset");

    // 1111 submit
    press(4'd1); press(4'd1);
    idle(1);
    chk("partial_count", digit_count, 2);
    press(4'd1); press(4'd1); press(4'hB);
    pw_m = 14'd1111; push(K_SUB, last_edge);
    idle(1);
    chk("after_submit_count", digit_count, 0);
    idle(2);

    // short entry rejected, password_in held
    press(4'd1); press(4'd2); press(4'hB);
    push(K_ERR, last_edge);
    idle(2);

    // ENTER with no digits
    press(4'hB);
    push(K_ERR, last_edge);
    idle(2);

    // change password to 2222
    press(4'hC);
    idle(1);
    chk("change_mode_on", change_mode, 1);
    press(4'd2); press(4'd2); press(4'd2); press(4'd2);
    idle(1);
    chk("change_mode_full", change_mode, 1);
    chk("change_full_count", digit_count, 4);
    press(4'hB);
    np_m = 14'd2222; push(K_CHG, last_edge);
    idle(1);
    chk("change_mode_off", change_mode, 0);
    press(4'd2); press(4'd2); press(4'd2); press(4'd2); press(4'hB);
    pw_m = 14'd2222; push(K_SUB, last_edge);
    idle(2);

    // fifth digit and mid-entry CHANGE ignored
    press(4'd9); press(4'd9); press(4'hC); press(4'd9); press(4'd9); press(4'd9);
    idle(1);
    chk("overflow_count", digit_count, 4);
    chk("overflow_change_mode", change_mode, 0);
    press(4'hB);
    pw_m = 14'd9999; push(K_SUB, last_edge);
    idle(2);

    // timeout of a partial entry
    press(4'd5); press(4'd6);
    push(K_ERR, last_edge + TO);
    idle(TO + 4);
    chk("timeout_count", digit_count, 0);
    press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'hB);
    pw_m = 14'd5678; push(K_SUB, last_edge);
    idle(2);

    // key on the last possible edge cancels the timeout, then expiry
    press(4'd3);
    idle(TO - 1);
    press(4'd4);
    push(K_ERR, last_edge + TO);
    idle(1);
    chk("cancel_count", digit_count, 2);
    idle(TO + 3);
    chk("expire_count", digit_count, 0);

    // reset mid-entry beats a simultaneous key
    press(4'd3); press(4'd4);
    idle(1);
    chk("pre_reset_count", digit_count, 2);
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b0;
    pw_m = '0; np_m = '0;
    chk_all_zero("midreset");
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    pw_m = 14'd1234; push(K_SUB, last_edge);
    idle(2);

    // clear then enter gives only an error
    press(4'd7); press(4'hA);
    idle(1);
    chk("clear_count", digit_count, 0);
    press(4'hB);
    push(K_ERR, last_edge);
    idle(2);

    // clear leaves change mode; unknown codes ignored
    press(4'hC); press(4'd1); press(4'hA);
    idle(1);
    chk("clear_exits_change", change_mode, 0);
    press(4'hE); press(4'd8);
    idle(1);
    chk("ignored_code_count", digit_count, 1);
    press(4'hA);
    idle(3);

    chk("missing_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
